// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared fault codes and the output-queue occupancy state type
// for instr_fetch_mem and its queue.
package ifetch_pkg;

  typedef logic [1:0] fault_t;

  localparam fault_t FAULT_NONE     = 2'd0;
  localparam fault_t FAULT_MISALIGN = 2'd1;
  localparam fault_t FAULT_RANGE    = 2'd2;

  typedef logic [1:0] occ_state_t;

  localparam occ_state_t ST_EMPTY   = 2'd0;
  localparam occ_state_t ST_PARTIAL = 2'd1;
  localparam occ_state_t ST_FULL    = 2'd2;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: power-of-two deep FIFO with synchronous flush. The head is
// presented combinationally and reads as zero while the queue is empty.
module ifetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && (r_count != '0);
  // A push into a full queue is only legal alongside a pop.
  assign w_push = push && ((r_count != (PW+1)'(DEPTH)) || w_pop);

  // Entry storage; not reset, the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  assign rdata = (r_count != '0) ? r_mem[r_rd] : '0;
  assign count = r_count;

endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: byte-addressed instruction store with a program-load port.
// An accepted fetch reads four bytes big-endian and enters the output queue
// at the accepting edge. Define IFETCH_FAULT_CHECK_EN to report misaligned and
// out-of-range fetches; otherwise pc[1:0] is ignored and addresses wrap.
module instr_fetch_mem #(
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_BYTES  = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  input  logic [ADDR_WIDTH-1:0]        req_pc,
  output logic                         req_ready,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr_data,
  output logic [ADDR_WIDTH-1:0]        instr_pc,
  output logic [1:0]                   instr_fault,
  input  logic                         flush,
  input  logic                         load_en,
  input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
  input  logic [7:0]                   load_data
);
  import ifetch_pkg::*;

  localparam int MA = $clog2(MEM_BYTES);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int EW = 32 + ADDR_WIDTH + 2;
`ifdef IFETCH_FAULT_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_OK_PC = ADDR_WIDTH'(MEM_BYTES - 4);
`endif

  logic [7:0]      r_mem [MEM_BYTES];
  logic            r_rdy_en;
  occ_state_t      r_state;
  occ_state_t      w_state_nxt;
  logic            w_accept;
  logic            w_deq;
  logic [CW:0]     w_count;
  logic [MA-1:0]   w_base;
  logic [31:0]     w_word;
  logic [31:0]     w_data;
  fault_t          w_fault;
  logic [EW-1:0]   w_head;

  // Program-load write port; storage is defined only by loads.
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  assign instr_valid = (r_state != ST_EMPTY);
  assign w_deq       = instr_valid && instr_ready;
  // Because the response enqueues at the accepting edge, nothing is ever in
  // flight between edges; a flush cycle refuses the request it would cancel.
  assign req_ready   = r_rdy_en && !load_en && !flush &&
                       ((r_state != ST_FULL) || w_deq);
  assign w_accept    = req_valid && req_ready;

  // Aligned word read plus optional fault classification of the request.
  always_comb begin
    w_base  = req_pc[MA-1:0] & ~MA'(3);
    w_word  = {r_mem[w_base], r_mem[w_base | MA'(1)],
               r_mem[w_base | MA'(2)], r_mem[w_base | MA'(3)]};
    w_fault = FAULT_NONE;
    w_data  = w_word;
`ifdef IFETCH_FAULT_CHECK_EN
    if (req_pc[1:0] != 2'b00)    w_fault = FAULT_MISALIGN;
    else if (req_pc > LAST_OK_PC) w_fault = FAULT_RANGE;
    if (w_fault != FAULT_NONE)   w_data  = '0;
`endif
  end

  // Occupancy state follows the (enqueue, dequeue) pair; flush empties it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_nxt = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (w_accept && !w_deq && (w_count == (CW+1)'(FIFO_DEPTH - 1)))
          w_state_nxt = ST_FULL;
        else if (!w_accept && w_deq && (w_count == (CW+1)'(1)))
          w_state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_deq && !w_accept) w_state_nxt = ST_PARTIAL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) w_state_nxt = ST_EMPTY;
  end

  // State register and post-reset request enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_EMPTY;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  ifetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (w_accept),
    .wdata   ({w_data, req_pc, w_fault}),
    .pop     (w_deq),
    .rdata   (w_head),
    .count   (w_count)
  );

  assign {instr_data, instr_pc, instr_fault} = w_head;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: scoreboard bench for instr_fetch_mem with default
// parameters. Expected fetch results are queued when a request is accepted
// and compared when the entry is dequeued.
module tb_instr_fetch_mem;

  typedef struct packed {
    logic [31:0] d;
    logic [63:0] pc;
    logic [1:0]  f;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        req_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;
  logic [1:0]  instr_fault;
  logic        flush;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [7:0]  load_data;

  int   checks;
  int   failures;
  logic [7:0] m_mem [64];
  exp_t sb[$];
  exp_t e;

  logic        obs_ready, obs_valid, obs_acc, obs_deq;
  logic [31:0] obs_data;
  logic [63:0] obs_pc;
  logic [1:0]  obs_fault;
  logic        load_ready_seen;

  instr_fetch_mem #(
    .ADDR_WIDTH (64),
    .MEM_BYTES  (64),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_ready   (req_ready),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault),
    .flush       (flush),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Reference fetch result derived from the bench's own copy of the storage.
  function automatic exp_t model(input logic [63:0] pc);
    exp_t r;
    logic [5:0] a;
    a    = pc[5:0] & 6'h3C;
    r.pc = pc;
    r.d  = {m_mem[a], m_mem[a + 6'd1], m_mem[a + 6'd2], m_mem[a + 6'd3]};
    r.f  = 2'd0;
`ifdef IFETCH_FAULT_CHECK_EN
    if (pc[1:0] != 2'b00) r.f = 2'd1;
    else if ((pc + 64'd3) >= 64'd64) r.f = 2'd2;
    if (r.f != 2'd0) r.d = 32'h0;
`endif
    return r;
  endfunction

  // Samples outputs mid-cycle, records accepted requests, then advances one edge.
  task automatic step;
    #1;
    obs_ready = req_ready;
    obs_valid = instr_valid;
    obs_data  = instr_data;
    obs_pc    = instr_pc;
    obs_fault = instr_fault;
    obs_acc   = req_valid && req_ready;
    obs_deq   = instr_valid && instr_ready;
    if (obs_acc) sb.push_back(model(req_pc));
    if (load_en) m_mem[load_addr] = load_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    req_valid = 1'b1;
    req_pc    = 64'd0;
    step();
    if (obs_ready) load_ready_seen = 1'b1;
    load_en   = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", instr_data); end
    checks++; if (instr_pc !== 64'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", instr_pc); end
    checks++; if (instr_fault !== 2'd0) begin failures++; $display("FAIL rst_fault got=%0d exp=0", instr_fault); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_early got=%b exp=0", req_ready); end
    @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise got=%b exp=1", req_ready); end
  endtask

  task automatic test_single;
    load_ready_seen = 1'b0;
    do_load(6'd0, 8'hF8);
    do_load(6'd1, 8'h40);
    do_load(6'd2, 8'h83);
    do_load(6'd3, 8'hE1);
    checks++; if (load_ready_seen !== 1'b0) begin failures++; $display("FAIL load_priority ready_during_load got=1 exp=0"); end
    instr_ready = 1'b1;
    req_valid = 1'b1;
    req_pc = 64'd0;
    step();
    checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", obs_ready); end
    req_valid = 1'b0;
    step();
    checks++; if (obs_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", obs_valid); end
    checks++;
    if ({obs_data, obs_pc, obs_fault} !== {32'hF84083E1, 64'd0, 2'd0}) begin
      failures++;
      $display("FAIL single_word got d=%h pc=%0d f=%0d exp d=F84083E1 pc=0 f=0", obs_data, obs_pc, obs_fault);
    end
    if (obs_deq && sb.size() != 0) e = sb.pop_front();
    step();
    checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", obs_valid); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] pcs [4];
    logic        rvs [4];
    logic        vals [4];
    logic [31:0] words [4];
    pcs   = '{64'd48, 64'd52, 64'd0, 64'd0};
    rvs   = '{1'b1, 1'b1, 1'b0, 1'b0};
    vals  = '{1'b0, 1'b1, 1'b1, 1'b0};
    words = '{32'h0, 32'h8B030022, 32'hCB0400A6, 32'h0};
    do_load(6'd48, 8'h8B); do_load(6'd49, 8'h03); do_load(6'd50, 8'h00); do_load(6'd51, 8'h22);
    do_load(6'd52, 8'hCB); do_load(6'd53, 8'h04); do_load(6'd54, 8'h00); do_load(6'd55, 8'hA6);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = rvs[i];
      req_pc    = pcs[i];
      step();
      checks++;
      if (obs_valid !== vals[i]) begin failures++; $display("FAIL bb_valid cyc=%0d got=%b exp=%b", i, obs_valid, vals[i]); end
      if (vals[i]) begin
        checks++;
        if (obs_data !== words[i]) begin failures++; $display("FAIL bb_word cyc=%0d got=%h exp=%h", i, obs_data, words[i]); end
      end
      if (obs_deq) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL bb_extra got d=%h pc=%0d exp none", obs_data, obs_pc); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_pc, obs_fault} !== e) begin
            failures++;
            $display("FAIL bb_sb got d=%h pc=%0d f=%0d exp d=%h pc=%0d f=%0d", obs_data, obs_pc, obs_fault, e.d, e.pc, e.f);
          end
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic        rvs [8];
    logic [63:0] pcs [8];
    logic        irs [8];
    logic        rdys [8];
    logic        vals [8];
    rvs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pcs  = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd48, 64'd0, 64'd0, 64'd0};
    irs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rdys = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vals = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      req_valid   = rvs[i];
      req_pc      = pcs[i];
      instr_ready = irs[i];
      step();
      checks++;
      if (obs_ready !== rdys[i]) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", i, obs_ready, rdys[i]); end
      checks++;
      if (obs_valid !== vals[i]) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, obs_valid, vals[i]); end
      if (obs_valid && !irs[i]) begin
        checks++;
        if (obs_data !== 32'hF84083E1) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=F84083E1", i, obs_data); end
      end
      if (obs_deq) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL bp_extra got d=%h pc=%0d exp none", obs_data, obs_pc); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_pc, obs_fault} !== e) begin
            failures++;
            $display("FAIL bp_sb got d=%h pc=%0d f=%0d exp d=%h pc=%0d f=%0d", obs_data, obs_pc, obs_fault, e.d, e.pc, e.f);
          end
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_fault;
    logic [63:0] pcs [4];
    pcs = '{64'd2, 64'd64, 64'd49, 64'd52};
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 4);
      req_pc    = (i < 4) ? pcs[i] : 64'd0;
      step();
      if (obs_deq) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL flt_extra got d=%h pc=%0d exp none", obs_data, obs_pc); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_pc, obs_fault} !== e) begin
            failures++;
            $display("FAIL flt_sb got d=%h pc=%0d f=%0d exp d=%h pc=%0d f=%0d", obs_data, obs_pc, obs_fault, e.d, e.pc, e.f);
          end
        end
        if (obs_pc == 64'd64) begin
          checks++;
`ifdef IFETCH_FAULT_CHECK_EN
          if ({obs_data, obs_fault} !== {32'h0, 2'd2}) begin
            failures++; $display("FAIL flt_pc64 got d=%h f=%0d exp d=0 f=2", obs_data, obs_fault);
          end
`else
          if ({obs_data, obs_fault} !== {32'hF84083E1, 2'd0}) begin
            failures++; $display("FAIL flt_pc64 got d=%h f=%0d exp d=F84083E1 f=0", obs_data, obs_fault);
          end
`endif
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_flush;
    instr_ready = 1'b0;
    req_valid = 1'b1;
    req_pc = 64'd0;
    step();
    req_pc = 64'd48;
    step();
    req_pc = 64'd52;
    flush = 1'b1;
    step();
    checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", obs_ready); end
    checks++; if (obs_valid !== 1'b1) begin failures++; $display("FAIL flush_full_before got=%b exp=1", obs_valid); end
    sb.delete();
    flush = 1'b0;
    req_valid = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_valid !== 1'b0) begin failures++; $display("FAIL flush_stale cyc=%0d got valid=%b d=%h exp valid=0", i, obs_valid, obs_data); end
    end
    req_valid = 1'b1;
    req_pc = 64'd52;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (!obs_deq || sb.size() == 0) begin
      failures++; $display("FAIL flush_refetch got valid=%b exp valid=1", obs_valid);
    end else begin
      e = sb.pop_front();
      if ({obs_data, obs_pc, obs_fault} !== e) begin
        failures++;
        $display("FAIL flush_refetch got d=%h pc=%0d f=%0d exp d=%h pc=%0d f=%0d", obs_data, obs_pc, obs_fault, e.d, e.pc, e.f);
      end
    end
  endtask

  task automatic test_reset_mid;
    instr_ready = 1'b0;
    req_valid = 1'b1;
    req_pc = 64'd0;
    step();
    req_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL midrst_partial got=%b exp=1", instr_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({instr_valid, instr_data, instr_pc, instr_fault, req_ready} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got v=%b d=%h pc=%h f=%0d r=%b exp all 0", instr_valid, instr_data, instr_pc, instr_fault, req_ready);
    end
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_early got=%b exp=0", obs_ready); end
    instr_ready = 1'b1;
    req_valid = 1'b1;
    req_pc = 64'd48;
    step();
    checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL midrst_accept got=%b exp=1", obs_ready); end
    req_valid = 1'b0;
    step();
    checks++;
    if (!obs_deq || obs_data !== 32'h8B030022) begin
      failures++; $display("FAIL midrst_readback got v=%b d=%h exp v=1 d=8B030022", obs_valid, obs_data);
    end
    if (obs_deq && sb.size() != 0) e = sb.pop_front();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_pc = 64'd0;
    instr_ready = 1'b0;
    flush = 1'b0;
    load_en = 1'b0;
    load_addr = 6'd0;
    load_data = 8'd0;
    load_ready_seen = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fault();
    test_flush();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
